packet_gen: RTL and testbench
=============================

PACKET_GEN -- requirements
Module: packet_gen

Interface
REQ-001 Parameter SEED, default 16'hACE1: LFSR reset value; SHALL be nonzero.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-low; rst=0 clears all state immediately.
REQ-004 en  input  1  generator enable; level-sensitive.
REQ-005 gap_cfg  input  4  idle cycles inserted after each accepted packet; 0 means back-to-back.
REQ-006 err_inj  input  1  when set at packet load, that packet's parity bit is inverted.
REQ-007 ready  input  1  downstream router controller can accept a packet this cycle.
REQ-008 valid  output  1  pkt_data holds a packet offered to downstream.
REQ-009 pkt_data  output  16  packet word: [15:14] dest, [13:1] payload, [0] parity.
REQ-010 pkt_count  output  16  number of accepted packets, saturating.

Function
REQ-011 Handshake SHALL be: transfer occurs on a posedge where valid=1 and ready=1; no other condition accepts a packet.
REQ-012 While valid=1 and ready=0, valid and pkt_data SHALL hold stable; en=0 SHALL NOT withdraw an offered packet.
REQ-013 FSM states SHALL be IDLE, SEND and GAP; valid=1 only in SEND.
REQ-014 IDLE: if en=1, go to SEND and load pkt_data; otherwise stay in IDLE.
REQ-015 SEND, no transfer: stay in SEND.
REQ-016 SEND, transfer with gap_cfg=0 and en=1: stay in SEND and load the next packet (back-to-back, no bubble).
REQ-017 SEND, transfer with gap_cfg!=0: go to GAP and load gap counter with gap_cfg.
REQ-018 SEND, transfer with gap_cfg=0 and en=0: go to IDLE.
REQ-019 GAP: decrement the counter each cycle; GAP SHALL last exactly gap_cfg cycles with valid=0.
REQ-020 GAP exit: when the counter reaches 1, go to SEND (loading a packet) if en=1, else to IDLE.
REQ-021 gap_cfg SHALL be sampled only at the transfer; later changes do not affect the current gap.
REQ-022 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
REQ-023 The LFSR SHALL advance exactly once per transfer, and never otherwise.
REQ-024 Dest counter: 2-bit, advances once per transfer, wraps 3->0; dest=3 packets are generated deliberately as invalid-destination traffic.
REQ-025 Loaded packet SHALL use the post-advance state: dest = counter, payload = lfsr[12:0].
REQ-026 Parity: bit0 = XOR of bits[15:1] (even parity over the whole word), inverted if err_inj=1 in the load cycle.
REQ-027 pkt_count SHALL increment on each transfer and saturate at 16'hFFFF.

Reset
REQ-028 rst=0 SHALL force state=IDLE, valid=0, pkt_data=16'h0000, pkt_count=0, dest counter=0, LFSR=SEED, gap counter=0, asynchronously.
REQ-029 Reset asserted mid-SEND or mid-GAP SHALL discard the pending packet without a transfer.
REQ-030 After release, the first packet SHALL again be packet 0.
REQ-031 No output SHALL change before the first posedge following rst release.

Verification
REQ-032 Reset release with en=1, ready=1, gap_cfg=0, err_inj=0:
- valid rises one cycle later; first pkt_data = 16'h19C2 (dest 0, payload 13'h0CE1, parity 0).
- Following packets arrive every cycle with dest 1,2,3,0.
REQ-033 Same setup with err_inj=1 at the first load -> first pkt_data = 16'h19C3; later packets use correct parity once err_inj=0.
REQ-034 Stall: ready=0 for 5 cycles while valid=1 -> pkt_data unchanged and pkt_count unchanged; transfer on the first ready=1 cycle; en dropped during the stall does not lower valid.
REQ-035 gap_cfg=3, ready=1: each transfer is followed by exactly 3 cycles of valid=0; gap_cfg changed to 1 during GAP has no effect until the next transfer.
REQ-036 rst pulsed low while in SEND with ready=0 -> valid=0 and pkt_count=0 immediately; after release the first packet is 16'h19C2.
REQ-037 Force pkt_count to 16'hFFFE, perform 3 transfers -> pkt_count = 16'hFFFF and holds.

Source files
------------

// File: rtl/packet_gen.sv
// packet_gen: test-traffic source for a router controller.
// Offers 16-bit packets {dest[1:0], payload[12:0], parity} on a valid/ready
// handshake. The payload comes from a 16-bit Fibonacci LFSR and dest from a
// 2-bit wrapping counter. Dest value 3 is emitted on purpose as
// invalid-destination traffic.
//
// Handshake: a packet moves on a posedge where valid=1 and ready=1, and on no
// other edge. Once valid is high it stays high, and pkt_data stays stable,
// until that transfer happens. Dropping en does not withdraw an offered
// packet.
module packet_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  gap_cfg,
    input  logic        err_inj,
    input  logic        ready,
    output logic        valid,
    output logic [15:0] pkt_data,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  dest_q, dest_d;
    logic [15:0] pkt_data_q, pkt_data_d;
    logic [15:0] pkt_count_q, pkt_count_d;

    logic        xfer;
    logic [15:0] lfsr_next;
    logic [1:0]  dest_next;

    // Builds a packet word. Parity makes the whole word even, and err_inj
    // flips the parity bit so that the packet is deliberately corrupt.
    function automatic logic [15:0] make_pkt(input logic [1:0]  dest,
                                             input logic [15:0] lfsr,
                                             input logic        err);
        logic [15:0] w;
        w    = {dest, lfsr[12:0], 1'b0};
        w[0] = (^w[15:1]) ^ err;
        return w;
    endfunction

    // Handshake decode, plus the next LFSR and dest values used on a transfer.
    // The LFSR taps are 16, 14, 13 and 11. It shifts left, and the feedback
    // enters at bit 0.
    always_comb begin
        xfer      = (state_q == SEND) && ready;
        lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dest_next = dest_q + 2'd1;
    end

    // Next-state logic for the FSM and the datapath.
    // The LFSR and dest advance only on a transfer. A packet loaded in the
    // same cycle as a transfer uses the advanced values. A packet loaded
    // from IDLE or GAP uses the values already held, because those values
    // were advanced at the last transfer.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        lfsr_d      = lfsr_q;
        dest_d      = dest_q;
        pkt_data_d  = pkt_data_q;
        pkt_count_d = pkt_count_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = SEND;
                    pkt_data_d = make_pkt(dest_q, lfsr_q, err_inj);
                end
            end
            SEND: begin
                if (xfer) begin
                    lfsr_d = lfsr_next;
                    dest_d = dest_next;
                    if (pkt_count_q != 16'hFFFF) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                    if (gap_cfg != 4'd0) begin
                        // gap_cfg is captured here only. Later changes do not
                        // affect the gap that is running.
                        state_d   = GAP;
                        gap_cnt_d = gap_cfg;
                    end else if (en) begin
                        pkt_data_d = make_pkt(dest_next, lfsr_next, err_inj);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    if (en) begin
                        state_d    = SEND;
                        pkt_data_d = make_pkt(dest_q, lfsr_q, err_inj);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. rst is asynchronous and active-low, and any pending
    // packet is dropped without a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gap_cnt_q   <= 4'd0;
            lfsr_q      <= SEED;
            dest_q      <= 2'd0;
            pkt_data_q  <= 16'h0000;
            pkt_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            lfsr_q      <= lfsr_d;
            dest_q      <= dest_d;
            pkt_data_q  <= pkt_data_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Output drive. valid is high only in SEND.
    always_comb begin
        valid     = (state_q == SEND);
        pkt_data  = pkt_data_q;
        pkt_count = pkt_count_q;
    end

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen. Expected packet words were worked out by hand
// from SEED=16'hACE1:
// 19C2 (dest0), 7386 (dest1), A70E (dest2), CE1F (dest3), 1C3D (dest0), 7878 (dest1).
module tb_packet_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  gap_cfg;
    logic        err_inj;
    logic        ready;
    logic        valid;
    logic [15:0] pkt_data;
    logic [15:0] pkt_count;

    int n_vec;
    int n_miss;

    packet_gen #(.SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gap_cfg   (gap_cfg),
        .err_inj   (err_inj),
        .ready     (ready),
        .valid     (valid),
        .pkt_data  (pkt_data),
        .pkt_count (pkt_count)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required summary before 200000");
        $fatal(1, "watchdog expired");
    end

    // Compares one value, counts the comparison, and reports a miscompare.
    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    // Advances one clock. Outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main stimulus.
    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b0;
        en      = 1'b1;
        gap_cfg = 4'd0;
        err_inj = 1'b0;
        ready   = 1'b1;

        // Reset state.
        tick();
        check_eq("rst_valid", {15'd0, valid}, 16'd0);
        check_eq("rst_data", pkt_data, 16'h0000);
        check_eq("rst_count", pkt_count, 16'h0000);

        // Release reset. Outputs must not move before the next posedge.
        rst = 1'b1;
        #2;
        check_eq("rel_valid_hold", {15'd0, valid}, 16'd0);
        tick();
        check_eq("first_valid", {15'd0, valid}, 16'd1);
        check_eq("first_data", pkt_data, 16'h19C2);
        check_eq("first_count", pkt_count, 16'd0);
        tick();
        check_eq("b2b_d1", pkt_data, 16'h7386);
        check_eq("b2b_cnt1", pkt_count, 16'd1);
        tick();
        check_eq("b2b_d2", pkt_data, 16'hA70E);
        tick();
        check_eq("b2b_d3", pkt_data, 16'hCE1F);
        tick();
        check_eq("b2b_d0", pkt_data, 16'h1C3D);
        check_eq("b2b_cnt4", pkt_count, 16'd4);
        check_eq("b2b_valid", {15'd0, valid}, 16'd1);

        // Reset pulse while in SEND with ready=0 must clear at once.
        ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", {15'd0, valid}, 16'd0);
        check_eq("midrst_count", pkt_count, 16'd0);
        check_eq("midrst_data", pkt_data, 16'h0000);

        // First packet after reset, with the error injected at load.
        err_inj = 1'b1;
        ready   = 1'b1;
        #3;
        rst = 1'b1;
        tick();
        check_eq("err_data", pkt_data, 16'h19C3);
        err_inj = 1'b0;
        tick();
        check_eq("err_next", pkt_data, 16'h7386);
        check_eq("err_cnt", pkt_count, 16'd1);

        // Stall for 5 cycles with en dropped. The packet must hold.
        ready = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", {15'd0, valid}, 16'd1);
            check_eq("stall_data", pkt_data, 16'h7386);
            check_eq("stall_cnt", pkt_count, 16'd1);
        end
        ready = 1'b1;
        en    = 1'b1;
        tick();
        check_eq("unstall_data", pkt_data, 16'hA70E);
        check_eq("unstall_cnt", pkt_count, 16'd2);

        // Transfer with gap 0 and en 0 goes to IDLE.
        en = 1'b0;
        tick();
        check_eq("to_idle_valid", {15'd0, valid}, 16'd0);
        check_eq("to_idle_cnt", pkt_count, 16'd3);
        tick();
        check_eq("idle_hold", {15'd0, valid}, 16'd0);
        en = 1'b1;
        tick();
        check_eq("idle_load", pkt_data, 16'hCE1F);
        check_eq("idle_load_v", {15'd0, valid}, 16'd1);

        // gap_cfg=3. Changing it to 1 during the gap has no effect.
        gap_cfg = 4'd3;
        tick();
        check_eq("gap3_cnt", pkt_count, 16'd4);
        gap_cfg = 4'd1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check_eq("gap3_valid", {15'd0, valid}, 16'd0);
        end
        tick();
        check_eq("gap3_exit_v", {15'd0, valid}, 16'd1);
        check_eq("gap3_exit_d", pkt_data, 16'h1C3D);

        // The new gap_cfg=1 applies from the next transfer.
        tick();
        check_eq("gap1_valid", {15'd0, valid}, 16'd0);
        tick();
        check_eq("gap1_exit_v", {15'd0, valid}, 16'd1);
        check_eq("gap1_exit_d", pkt_data, 16'h7878);
        check_eq("gap1_cnt", pkt_count, 16'd5);

        // Saturation: preload the counter to FFFE, then do 3 transfers.
        ready   = 1'b0;
        gap_cfg = 4'd0;
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFE;
        #1;
        release dut.pkt_count_q;
        #1;
        check_eq("sat_preload", pkt_count, 16'hFFFE);
        ready = 1'b1;
        tick();
        check_eq("sat_1", pkt_count, 16'hFFFF);
        tick();
        check_eq("sat_2", pkt_count, 16'hFFFF);
        tick();
        check_eq("sat_3", pkt_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
